// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 line-capture block.
// Provides default geometry, pixel types, bus bit positions and FSM states.
package hub75_pkg;

   localparam int COLS_DEF     = 64;
   localparam int ROW_BITS_DEF = 5;

   // Raw HUB75 bus as seen by the synchronizer:
   // [5:0] {R1,G1,B1,R2,G2,B2}, [10:6] {E,D,C,B,A},
   // [11] hub_clk, [12] LAT, [13] OE_N
   localparam int HUB_W    = 14;
   localparam int ADDR_LSB = 6;
   localparam int BIT_CLK  = 11;
   localparam int BIT_LAT  = 12;
   localparam int BIT_OE   = 13;

   typedef logic [2:0] rgb_t;

   typedef struct packed {
      rgb_t upper;
      rgb_t lower;
   } hub_pix_t;

   typedef enum logic {
      ST_IDLE,
      ST_DUMP
   } cap_state_t;

   function automatic int addr_w(input int cols, input int row_bits);
      return 1 + row_bits + $clog2(cols);
   endfunction

   localparam int ADDR_W_DEF = 1 + ROW_BITS_DEF + $clog2(COLS_DEF);

endpackage

// File: rtl/hub75_input_sync.sv
// Synchronizes the raw HUB75 bus into clk_in and flags hub_clk/LAT rises.
// Ports: clk_in, rst_n, raw bus in; synchronized levels, clk_rise, lat_rise.
module hub75_input_sync
   import hub75_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic [HUB_W-1:0] raw,
   output logic [HUB_W-1:0] lvl,
   output logic             clk_rise,
   output logic             lat_rise
);

   logic [HUB_W-1:0] sr [STAGES];
   logic             clk_prev;
   logic             lat_prev;

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            sr[i] <= '0;
         end
         clk_prev <= 1'b0;
         lat_prev <= 1'b0;
      end else begin
         sr[0] <= raw;
         for (int i = 1; i < STAGES; i++) begin
            sr[i] <= sr[i-1];
         end
         clk_prev <= sr[STAGES-1][BIT_CLK];
         lat_prev <= sr[STAGES-1][BIT_LAT];
      end
   end

   // Levels and rise pulses come from the same flop, so colour
   // data is aligned with the clk_rise that qualifies it.
   assign lvl      = sr[STAGES-1];
   assign clk_rise = sr[STAGES-1][BIT_CLK] & ~clk_prev;
   assign lat_rise = sr[STAGES-1][BIT_LAT] & ~lat_prev;

endmodule

// File: rtl/hub75_line_capture.sv
// Reconstructs latched HUB75 line pairs and streams them to a frame store.
// Ports: HUB75 bus in; wr_en/wr_addr/wr_data out; line/frame/error pulses, busy.
module hub75_line_capture
   import hub75_pkg::*;
#(
   parameter int COLS        = COLS_DEF,
   parameter int ROW_BITS    = ROW_BITS_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk_in,
   input  logic                          rst_n,
   input  logic                          R1_data,
   input  logic                          G1_data,
   input  logic                          B1_data,
   input  logic                          R2_data,
   input  logic                          G2_data,
   input  logic                          B2_data,
   input  logic                          A,
   input  logic                          B,
   input  logic                          C,
   input  logic                          D,
   input  logic                          E,
   input  logic                          hub_clk,
   input  logic                          LAT,
   input  logic                          OE_N,
   output logic                          wr_en,
   output logic [ROW_BITS+$clog2(COLS):0] wr_addr,
   output logic [2:0]                    wr_data,
   output logic                          line_done,
   output logic                          frame_done,
   output logic                          len_err,
   output logic                          ovr_err,
   output logic                          busy
);

   localparam int COL_W  = $clog2(COLS);
   localparam int CNT_W  = COL_W + 1;
   localparam int ADDR_W = addr_w(COLS, ROW_BITS);

   localparam logic [CNT_W-1:0] COLS_C  = CNT_W'(COLS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [COL_W:0]   IDX_ONE = (COL_W+1)'(1);

   logic [HUB_W-1:0]    raw;
   logic [HUB_W-1:0]    lvl;
   logic                clk_rise;
   logic                lat_rise;
   logic                unused_lvl;

   hub_pix_t            pix;
   logic [ROW_BITS-1:0] row_in;

   hub_pix_t            cap_buf [COLS];
   hub_pix_t            dmp_buf [COLS];

   logic [CNT_W-1:0]    col_cnt;
   logic                line_bad;
   logic [ROW_BITS-1:0] row_q;
   logic [COL_W:0]      dmp_idx;

   cap_state_t          state_q;
   cap_state_t          state_d;

   logic                len_ok;
   logic                accept;
   logic                last_wr;
   hub_pix_t            dmp_pix;

   assign raw = {OE_N, LAT, hub_clk,
                 E, D, C, B, A,
                 R1_data, G1_data, B1_data,
                 R2_data, G2_data, B2_data};

   hub75_input_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .raw      (raw),
      .lvl      (lvl),
      .clk_rise (clk_rise),
      .lat_rise (lat_rise)
   );

   assign pix    = hub_pix_t'(lvl[5:0]);
   assign row_in = lvl[ADDR_LSB +: ROW_BITS];

   // OE_N, the strobe levels and any row lines beyond ROW_BITS
   // are observed but never steer capture.
   assign unused_lvl = ^lvl;

   // A line is good only if exactly COLS clocks arrived since the
   // previous latch; overflow clocks set line_bad instead of counting.
   assign len_ok  = !line_bad && (col_cnt == COLS_C);
   assign accept  = lat_rise && len_ok && (state_q == ST_IDLE);
   assign last_wr = (state_q == ST_DUMP) && (dmp_idx == '1);
   assign dmp_pix = dmp_buf[dmp_idx[COL_W-1:0]];

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         col_cnt  <= '0;
         line_bad <= 1'b0;
      end else if (lat_rise) begin
         line_bad <= 1'b0;
         col_cnt  <= clk_rise ? CNT_ONE : '0;
      end else if (clk_rise) begin
         if (col_cnt == COLS_C) begin
            line_bad <= 1'b1;
         end else begin
            col_cnt <= col_cnt + CNT_ONE;
         end
      end
   end

   // Pixel storage carries no reset: validity lives in col_cnt/state.
   // A clock rise coincident with a latch opens the next line, and
   // the copy below still sees the old column 0.
   always_ff @(posedge clk_in) begin
      if (clk_rise) begin
         if (lat_rise) begin
            cap_buf[0] <= pix;
         end else if (col_cnt < COLS_C) begin
            cap_buf[col_cnt[COL_W-1:0]] <= pix;
         end
      end
      if (accept) begin
         dmp_buf <= cap_buf;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      busy    = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_DUMP;
            end
         end
         ST_DUMP: begin
            wr_en   = 1'b1;
            busy    = 1'b1;
            wr_addr = ADDR_W'({dmp_idx[COL_W], row_q,
                               dmp_idx[COL_W-1:0]});
            wr_data = dmp_idx[COL_W] ? dmp_pix.lower
                                     : dmp_pix.upper;
            if (last_wr) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         dmp_idx    <= '0;
         row_q      <= '0;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
         len_err    <= 1'b0;
         ovr_err    <= 1'b0;
      end else begin
         if (accept) begin
            row_q   <= row_in;
            dmp_idx <= '0;
         end else if (state_q == ST_DUMP) begin
            dmp_idx <= dmp_idx + IDX_ONE;
         end
         line_done  <= last_wr;
         frame_done <= last_wr && (&row_q);
         len_err    <= lat_rise && !len_ok;
         ovr_err    <= lat_rise && len_ok
                       && (state_q == ST_DUMP);
      end
   end

endmodule

// File: tb/tb_hub75_line_capture.sv
// Directed bench for hub75_line_capture with a write scoreboard.
// Drives HUB75 lines, checks every frame-store write and status pulse.
`timescale 1ns/1ps
module tb_hub75_line_capture;

   logic        clk_in = 1'b0;
   logic        rst_n  = 1'b0;
   logic        R1_data = 0, G1_data = 0, B1_data = 0;
   logic        R2_data = 0, G2_data = 0, B2_data = 0;
   logic        A = 0, B = 0, C = 0, D = 0, E = 0;
   logic        hub_clk = 0, LAT = 0, OE_N = 1;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [2:0]  wr_data;
   logic        line_done, frame_done, len_err, ovr_err, busy;

   int checks = 0;
   int errors = 0;
   int wr_seen = 0;
   int ld_cnt = 0, fd_cnt = 0, le_cnt = 0, oe_cnt = 0;

   logic [14:0] sb [$];
   logic [5:0]  line_px [64];

   always #5 clk_in = ~clk_in;

   hub75_line_capture #(
      .COLS        (64),
      .ROW_BITS    (5),
      .SYNC_STAGES (2)
   ) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .R1_data    (R1_data),
      .G1_data    (G1_data),
      .B1_data    (B1_data),
      .R2_data    (R2_data),
      .G2_data    (G2_data),
      .B2_data    (B2_data),
      .A          (A),
      .B          (B),
      .C          (C),
      .D          (D),
      .E          (E),
      .hub_clk    (hub_clk),
      .LAT        (LAT),
      .OE_N       (OE_N),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .line_done  (line_done),
      .frame_done (frame_done),
      .len_err    (len_err),
      .ovr_err    (ovr_err),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] pix_of(input int row, input int col,
                                         input int seed);
      logic [2:0] k;
      k = col[2:0];
      if (seed == 0) return {k, k ^ 3'b101};
      return 6'((col * 13 + row * 7 + seed * 29) ^ (col >> 2));
   endfunction

   task automatic push_line(input int row);
      logic [4:0] r;
      logic [5:0] cc;
      r = row[4:0];
      for (int h = 0; h < 2; h++) begin
         for (int c = 0; c < 64; c++) begin
            cc = c[5:0];
            sb.push_back({h[0], r, cc,
                          (h == 1) ? line_px[c][2:0] : line_px[c][5:3]});
         end
      end
   endtask

   task automatic set_pix(input logic [5:0] p);
      {R1_data, G1_data, B1_data, R2_data, G2_data, B2_data} = p;
   endtask

   task automatic set_row(input int row);
      {E, D, C, B, A} = row[4:0];
   endtask

   task automatic shift(input logic [5:0] p);
      @(negedge clk_in);
      set_pix(p);
      repeat (3) @(negedge clk_in);
      hub_clk = 1'b1;
      repeat (4) @(negedge clk_in);
      hub_clk = 1'b0;
   endtask

   task automatic send_cols(input int row, input int n, input int seed);
      for (int c = 0; c < n; c++) begin
         line_px[c] = pix_of(row, c, seed);
         shift(line_px[c]);
      end
   endtask

   task automatic latch(input int row, input bit push);
      @(negedge clk_in);
      set_row(row);
      repeat (2) @(negedge clk_in);
      if (push) push_line(row);
      LAT = 1'b1;
      repeat (3) @(negedge clk_in);
      LAT = 1'b0;
      repeat (2) @(negedge clk_in);
   endtask

   task automatic wait_idle(input string tag);
      int i;
      for (i = 0; i < 2000; i++) begin
         @(posedge clk_in);
         if (sb.size() == 0 && !busy) break;
      end
      chk(tag, (i < 2000), 1);
      repeat (3) @(posedge clk_in);
      chk({tag, "_sb_left"}, sb.size(), 0);
   endtask

   always @(negedge clk_in) begin
      logic [14:0] e;
      if (!rst_n) begin
         chk("reset_out", {wr_en, line_done, frame_done, len_err,
                           ovr_err, busy, wr_addr, wr_data}, 0);
         sb.delete();
      end else begin
         if (wr_en || busy) chk("busy_eq_wr_en", busy, wr_en);
         if (wr_en) begin
            wr_seen++;
            chk("sb_has_entry", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("wr_addr", wr_addr, e[14:3]);
               chk("wr_data", wr_data, e[2:0]);
            end
         end
         if (frame_done) chk("fd_with_ld", line_done, 1);
         if (line_done)  ld_cnt++;
         if (frame_done) fd_cnt++;
         if (len_err)    le_cnt++;
         if (ovr_err)    oe_cnt++;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int base, ld0, fd0, i;
      logic [5:0] p0;

      repeat (4) @(negedge clk_in);
      rst_n = 1'b1;
      @(negedge clk_in);
      chk("post_reset_busy", busy, 0);
      chk("post_reset_wr_en", wr_en, 0);

      // loopback-style line, row 5, column k carries k[2:0]
      base = wr_seen;
      send_cols(5, 64, 0);
      latch(5, 1);
      wait_idle("line5");
      chk("line5_writes", wr_seen - base, 128);
      chk("line5_ld", ld_cnt, 1);
      chk("line5_fd", fd_cnt, 0);
      chk("line5_err", le_cnt + oe_cnt, 0);

      // short line dropped, next full line accepted
      base = wr_seen;
      send_cols(3, 63, 1);
      latch(3, 0);
      repeat (20) @(posedge clk_in);
      chk("short_len_err", le_cnt, 1);
      chk("short_writes", wr_seen - base, 0);
      chk("short_busy", busy, 0);
      send_cols(3, 64, 2);
      latch(3, 1);
      wait_idle("line3");
      chk("line3_writes", wr_seen - base, 128);
      chk("line3_ld", ld_cnt, 2);
      chk("line3_len_err", le_cnt, 1);

      // back-to-back latch while dumping: second line dropped
      base = wr_seen;
      send_cols(7, 64, 5);
      @(negedge clk_in);
      set_row(7);
      repeat (2) @(negedge clk_in);
      push_line(7);
      for (int c = 0; c < 64; c++) begin
         set_pix(pix_of(8, c, 6));
         hub_clk = 1'b1;
         if (c == 0) LAT = 1'b1;
         @(negedge clk_in);
         hub_clk = 1'b0;
         @(negedge clk_in);
         LAT = 1'b0;
      end
      LAT = 1'b1;
      repeat (3) @(negedge clk_in);
      LAT = 1'b0;
      wait_idle("ovr");
      chk("ovr_err", oe_cnt, 1);
      chk("ovr_writes", wr_seen - base, 128);
      chk("ovr_ld", ld_cnt, 3);
      chk("ovr_len_err", le_cnt, 1);

      // full frame: frame_done only with row 31
      fd0 = fd_cnt;
      ld0 = ld_cnt;
      for (int r = 0; r < 32; r++) begin
         send_cols(r, 64, 10 + r);
         latch(r, 1);
         wait_idle("frame_line");
         if (r == 30) chk("fd_before_31", fd_cnt - fd0, 0);
      end
      chk("frame_fd", fd_cnt - fd0, 1);
      chk("frame_ld", ld_cnt - ld0, 32);

      // reset during dump write 40
      ld0 = ld_cnt;
      base = wr_seen;
      send_cols(12, 64, 3);
      latch(12, 1);
      for (i = 0; i < 1000; i++) begin
         @(posedge clk_in);
         if (wr_seen - base >= 40) break;
      end
      chk("rst_wait", (i < 1000), 1);
      @(negedge clk_in);
      #1 rst_n = 1'b0;
      @(negedge clk_in);
      #1 rst_n = 1'b1;
      @(negedge clk_in);
      chk("rst_busy", busy, 0);
      chk("rst_wr_en", wr_en, 0);
      repeat (150) @(posedge clk_in);
      chk("rst_writes", ((wr_seen - base) >= 40) &&
                        ((wr_seen - base) <= 41), 1);
      chk("rst_no_ld", ld_cnt, ld0);
      base = wr_seen;
      send_cols(20, 64, 4);
      latch(20, 1);
      wait_idle("after_rst");
      chk("after_rst_writes", wr_seen - base, 128);
      chk("after_rst_ld", ld_cnt, ld0 + 1);

      // clock rise together with latch rise opens the next line
      ld0 = ld_cnt;
      base = wr_seen;
      send_cols(2, 64, 7);
      @(negedge clk_in);
      set_row(2);
      repeat (2) @(negedge clk_in);
      push_line(2);
      p0 = pix_of(9, 0, 8);
      set_pix(p0);
      repeat (3) @(negedge clk_in);
      LAT = 1'b1;
      hub_clk = 1'b1;
      repeat (4) @(negedge clk_in);
      LAT = 1'b0;
      hub_clk = 1'b0;
      line_px[0] = p0;
      for (int c = 1; c < 64; c++) begin
         line_px[c] = pix_of(9, c, 8);
         shift(line_px[c]);
      end
      latch(9, 1);
      wait_idle("same_cycle");
      chk("same_cycle_writes", wr_seen - base, 256);
      chk("same_cycle_ld", ld_cnt, ld0 + 2);
      chk("final_len_err", le_cnt, 1);
      chk("final_ovr_err", oe_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
